// File: rtl/pe_mac_rf.sv
`default_nettype none
// ============================================================================
// Module      : pe_mac_rf
// Description : Two-stage MAC processing element with a register file of
//               signed accumulators, optional saturation and sticky overflow.
// Revision    : 1.0 - initial release
// ============================================================================
module pe_mac_rf #(
  parameter int INPUT_WIDTH    = 8,
  parameter int OUTPUT_WIDTH   = 32,
  parameter int REG_FILE_DEPTH = 8,
  parameter int REG_FILE_WIDTH = 3,
  parameter int SATURATE       = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [1:0]                in_op,
  input  logic [INPUT_WIDTH-1:0]    data_in_1,
  input  logic [INPUT_WIDTH-1:0]    data_in_2,
  input  logic [REG_FILE_WIDTH-1:0] in_addr,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [OUTPUT_WIDTH-1:0]   data_out,
  output logic [REG_FILE_WIDTH-1:0] out_addr,
  output logic                      out_ovf
);

  localparam int c_PROD_W = 2 * INPUT_WIDTH;
  localparam logic [1:0] c_OP_MAC      = 2'b00;
  localparam logic [1:0] c_OP_SET      = 2'b01;
  localparam logic [1:0] c_OP_READ_CLR = 2'b11;
  localparam logic [OUTPUT_WIDTH-1:0] c_ACC_MAX = {1'b0, {(OUTPUT_WIDTH-1){1'b1}}};
  localparam logic [OUTPUT_WIDTH-1:0] c_ACC_MIN = {1'b1, {(OUTPUT_WIDTH-1){1'b0}}};
  localparam logic [REG_FILE_WIDTH:0] c_DEPTH   = (REG_FILE_WIDTH+1)'(REG_FILE_DEPTH);

  generate
    if (OUTPUT_WIDTH < 2 * INPUT_WIDTH) begin : g_width_check
      $error("pe_mac_rf: OUTPUT_WIDTH must be >= 2*INPUT_WIDTH");
    end
    if (REG_FILE_WIDTH != $clog2(REG_FILE_DEPTH)) begin : g_addr_check
      $error("pe_mac_rf: REG_FILE_WIDTH must equal clog2(REG_FILE_DEPTH)");
    end
  endgenerate

  logic                             r_s1_valid;
  logic [1:0]                       r_s1_op;
  logic [REG_FILE_WIDTH-1:0]        r_s1_addr;
  logic signed [INPUT_WIDTH-1:0]    r_s1_a;
  logic signed [INPUT_WIDTH-1:0]    r_s1_b;
  logic signed [OUTPUT_WIDTH-1:0]   r_rf [REG_FILE_DEPTH];
  logic [REG_FILE_DEPTH-1:0]        r_ovf;
  logic                             r_out_valid;
  logic [OUTPUT_WIDTH-1:0]          r_data_out;
  logic [REG_FILE_WIDTH-1:0]        r_out_addr;
  logic                             r_out_ovf;

  logic                             w_advance;
  logic                             w_hit;
  logic signed [c_PROD_W-1:0]       w_prod;
  logic signed [OUTPUT_WIDTH-1:0]   w_prod_ext;
  logic signed [OUTPUT_WIDTH-1:0]   w_acc;
  logic [OUTPUT_WIDTH:0]            w_sum;
  logic                             w_mac_ovf;
  logic [OUTPUT_WIDTH-1:0]          w_mac_res;

  assign w_advance  = !r_out_valid || out_ready;
  assign in_ready   = w_advance && !rst;

  assign w_prod     = r_s1_a * r_s1_b;
  assign w_prod_ext = OUTPUT_WIDTH'(w_prod);
  assign w_hit      = r_s1_valid && ({1'b0, r_s1_addr} < c_DEPTH);
  assign w_acc      = r_rf[r_s1_addr];

  // One guard bit: overflow shows up as disagreement of the top two sum bits.
  assign w_sum      = {w_acc[OUTPUT_WIDTH-1], w_acc} + {w_prod_ext[OUTPUT_WIDTH-1], w_prod_ext};
  assign w_mac_ovf  = w_sum[OUTPUT_WIDTH] ^ w_sum[OUTPUT_WIDTH-1];

  always_comb begin
    w_mac_res = w_sum[OUTPUT_WIDTH-1:0];
    if (w_mac_ovf && (SATURATE != 0)) begin
      w_mac_res = w_sum[OUTPUT_WIDTH] ? c_ACC_MIN : c_ACC_MAX;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_valid  <= 1'b0;
      r_s1_op     <= '0;
      r_s1_addr   <= '0;
      r_s1_a      <= '0;
      r_s1_b      <= '0;
      for (int i = 0; i < REG_FILE_DEPTH; i++) begin
        r_rf[i] <= '0;
      end
      r_ovf       <= '0;
      r_out_valid <= 1'b0;
      r_data_out  <= '0;
      r_out_addr  <= '0;
      r_out_ovf   <= 1'b0;
    end else if (w_advance) begin
      r_s1_valid <= in_valid && in_ready;
      if (in_valid && in_ready) begin
        r_s1_op   <= in_op;
        r_s1_addr <= in_addr;
        r_s1_a    <= $signed(data_in_1);
        r_s1_b    <= $signed(data_in_2);
      end

      if (out_ready) begin
        r_out_valid <= 1'b0;
      end

      if (w_hit) begin
        case (r_s1_op)
          c_OP_MAC: begin
            r_rf[r_s1_addr] <= $signed(w_mac_res);
            if (w_mac_ovf) begin
              r_ovf[r_s1_addr] <= 1'b1;
            end
          end
          c_OP_SET: begin
            r_rf[r_s1_addr]  <= w_prod_ext;
            r_ovf[r_s1_addr] <= 1'b0;
          end
          default: begin
            r_out_valid <= 1'b1;
            r_data_out  <= w_acc;
            r_out_addr  <= r_s1_addr;
            r_out_ovf   <= r_ovf[r_s1_addr];
            if (r_s1_op == c_OP_READ_CLR) begin
              r_rf[r_s1_addr]  <= '0;
              r_ovf[r_s1_addr] <= 1'b0;
            end
          end
        endcase
      end
    end
  end

  assign out_valid = r_out_valid;
  assign data_out  = r_data_out;
  assign out_addr  = r_out_addr;
  assign out_ovf   = r_out_ovf;

endmodule
`default_nettype wire

// File: tb/tb_pe_mac_rf.sv
`default_nettype none
// ============================================================================
// Module      : tb_pe_mac_rf
// Description : Scoreboard bench driving three pe_mac_rf variants in lockstep.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pe_mac_rf;

  localparam int N = 3;  // 0: OW32/sat/depth8, 1: OW16/sat/depth6, 2: OW16/wrap/depth6

  typedef struct {
    longint data;
    int     addr;
    bit     ovf;
  } exp_t;

  logic         clk       = 1'b0;
  logic         rst       = 1'b1;
  logic         drv_valid = 1'b0;
  logic         in_valid;
  logic [1:0]   in_op     = '0;
  logic [7:0]   d1        = '0;
  logic [7:0]   d2        = '0;
  logic [2:0]   in_addr   = '0;
  logic         out_ready = 1'b0;
  logic [N-1:0] rdy;
  logic [N-1:0] ov;
  logic [N-1:0] oovf;
  logic [31:0]  dout_m;
  logic [15:0]  dout_s;
  logic [15:0]  dout_w;
  logic [2:0]   oaddr_m;
  logic [2:0]   oaddr_s;
  logic [2:0]   oaddr_w;
  longint       dout  [N];
  int           oaddr [N];

  bit     hold_lo = 1'b0;
  bit     rand_bp = 1'b0;
  int     n_cmp   = 0;
  int     n_err   = 0;
  exp_t   q [N][$];
  longint m_rf  [N][8];
  bit     m_ovf [N][8];
  bit     hold   [N];
  longint h_data [N];
  int     h_addr [N];
  bit     h_ovf  [N];
  exp_t   mon_e;

  assign in_valid = drv_valid && (&rdy);

  always #5 clk = ~clk;

  always_comb begin
    dout[0]  = longint'($signed(dout_m));
    dout[1]  = longint'($signed(dout_s));
    dout[2]  = longint'($signed(dout_w));
    oaddr[0] = int'(oaddr_m);
    oaddr[1] = int'(oaddr_s);
    oaddr[2] = int'(oaddr_w);
  end

  pe_mac_rf #(.INPUT_WIDTH(8), .OUTPUT_WIDTH(32), .REG_FILE_DEPTH(8),
              .REG_FILE_WIDTH(3), .SATURATE(1)) u_main (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy[0]), .in_op(in_op),
    .data_in_1(d1), .data_in_2(d2), .in_addr(in_addr), .out_valid(ov[0]),
    .out_ready(out_ready), .data_out(dout_m), .out_addr(oaddr_m), .out_ovf(oovf[0]));

  pe_mac_rf #(.INPUT_WIDTH(8), .OUTPUT_WIDTH(16), .REG_FILE_DEPTH(6),
              .REG_FILE_WIDTH(3), .SATURATE(1)) u_sat (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy[1]), .in_op(in_op),
    .data_in_1(d1), .data_in_2(d2), .in_addr(in_addr), .out_valid(ov[1]),
    .out_ready(out_ready), .data_out(dout_s), .out_addr(oaddr_s), .out_ovf(oovf[1]));

  pe_mac_rf #(.INPUT_WIDTH(8), .OUTPUT_WIDTH(16), .REG_FILE_DEPTH(6),
              .REG_FILE_WIDTH(3), .SATURATE(0)) u_wrap (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy[2]), .in_op(in_op),
    .data_in_1(d1), .data_in_2(d2), .in_addr(in_addr), .out_valid(ov[2]),
    .out_ready(out_ready), .data_out(dout_w), .out_addr(oaddr_w), .out_ovf(oovf[2]));

  function automatic int ow_of(int k);
    return (k == 0) ? 32 : 16;
  endfunction

  function automatic bit sat_of(int k);
    return k != 2;
  endfunction

  function automatic int dep_of(int k);
    return (k == 0) ? 8 : 6;
  endfunction

  function automatic void chk(string nm, longint act, longint exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endfunction

  // Reference: each accepted op is applied to plain integer accumulators in order.
  function automatic void model_apply(int op, int addr, int a, int b);
    longint p, s, mx, mn, m;
    exp_t   e;
    for (int k = 0; k < N; k++) begin
      if (addr >= dep_of(k)) continue;
      p  = longint'(a) * longint'(b);
      m  = longint'(1) << ow_of(k);
      mx = (m / 2) - 1;
      mn = -(m / 2);
      case (op)
        0: begin
          s = m_rf[k][addr] + p;
          if (s > mx || s < mn) begin
            m_ovf[k][addr] = 1'b1;
            if (sat_of(k)) s = (s > mx) ? mx : mn;
            else begin
              s = ((s % m) + m) % m;
              if (s > mx) s = s - m;
            end
          end
          m_rf[k][addr] = s;
        end
        1: begin
          m_rf[k][addr]  = p;
          m_ovf[k][addr] = 1'b0;
        end
        default: begin
          e.data = m_rf[k][addr];
          e.addr = addr;
          e.ovf  = m_ovf[k][addr];
          q[k].push_back(e);
          if (op == 3) begin
            m_rf[k][addr]  = 0;
            m_ovf[k][addr] = 1'b0;
          end
        end
      endcase
    end
  endfunction

  function automatic void model_clear();
    for (int k = 0; k < N; k++) begin
      q[k].delete();
      for (int i = 0; i < 8; i++) begin
        m_rf[k][i]  = 0;
        m_ovf[k][i] = 1'b0;
      end
    end
  endfunction

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic send(input int op, input int addr, input int a, input int b);
    int w = 0;
    in_op     = op[1:0];
    in_addr   = addr[2:0];
    d1        = a[7:0];
    d2        = b[7:0];
    drv_valid = 1'b1;
    @(negedge clk);
    while (!(&rdy) && w < 500) begin
      @(negedge clk);
      w++;
    end
    n_cmp++;
    if (&rdy) begin
      model_apply(op, addr, a, b);
      @(posedge clk);
      #1;
    end else begin
      n_err++;
      $display("FAIL send_timeout: in_ready=%b, required all ready", rdy);
    end
    drv_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int t = 0;
    while ((q[0].size() + q[1].size() + q[2].size()) != 0 && t < 3000) begin
      @(posedge clk);
      t++;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < N; k++) chk($sformatf("drain_queue[%0d]", k), q[k].size(), 0);
  endtask

  always begin
    @(posedge clk);
    #2;
    out_ready = hold_lo ? 1'b0 : (rand_bp ? ($urandom_range(0, 3) != 0) : 1'b1);
  end

  // Monitor: pops on every output handshake and checks stability while stalled.
  always @(negedge clk) begin
    for (int k = 0; k < N; k++) begin
      if (rst) begin
        hold[k] = 1'b0;
      end else begin
        if (hold[k] && ov[k]) begin
          chk($sformatf("stable_data[%0d]", k), dout[k], h_data[k]);
          chk($sformatf("stable_addr[%0d]", k), oaddr[k], h_addr[k]);
          chk($sformatf("stable_ovf[%0d]", k), oovf[k], h_ovf[k]);
        end
        if (ov[k] && !out_ready) chk($sformatf("in_ready_stall[%0d]", k), rdy[k], 0);
        if (ov[k] && out_ready) begin
          if (q[k].size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL unexpected_output[%0d]: data=%0d addr=%0d, required no output",
                     k, dout[k], oaddr[k]);
          end else begin
            mon_e = q[k].pop_front();
            chk($sformatf("data_out[%0d]", k), dout[k], mon_e.data);
            chk($sformatf("out_addr[%0d]", k), oaddr[k], mon_e.addr);
            chk($sformatf("out_ovf[%0d]", k), oovf[k], mon_e.ovf);
          end
        end
        hold[k]   = ov[k] && !out_ready;
        h_data[k] = dout[k];
        h_addr[k] = oaddr[k];
        h_ovf[k]  = oovf[k];
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    model_clear();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < N; k++) chk($sformatf("rst_in_ready[%0d]", k), rdy[k], 0);
    @(posedge clk);
    #1;
    for (int k = 0; k < N; k++) begin
      chk($sformatf("rst_out_valid[%0d]", k), ov[k], 0);
      chk($sformatf("rst_data_out[%0d]", k), dout[k], 0);
      chk($sformatf("rst_out_addr[%0d]", k), oaddr[k], 0);
      chk($sformatf("rst_out_ovf[%0d]", k), oovf[k], 0);
    end
    rst = 1'b0;

    // Basic MAC, then a second READ to show the entry is retained
    send(1, 2, -128, -128);
    repeat (3) send(0, 2, -128, -128);
    send(2, 2, 0, 0);
    send(2, 2, 0, 0);

    // Saturation / wrap sequence
    send(1, 3, 127, 127);
    repeat (2) send(0, 3, 127, 127);
    send(3, 3, 0, 0);
    send(2, 3, 0, 0);

    // Back-to-back hazards on the top address
    send(0, 7, 3, 4);
    send(0, 7, 5, 6);
    send(2, 7, 0, 0);

    // Stall the output for a few cycles while ops keep arriving
    hold_lo = 1'b1;
    fork
      begin
        repeat (6) @(negedge clk);
        hold_lo = 1'b0;
      end
    join_none
    send(2, 7, 0, 0);
    send(1, 5, 7, -9);
    send(0, 5, -3, 11);
    send(2, 5, 0, 0);
    send(3, 7, 0, 0);
    send(2, 7, 0, 0);

    // Isolation between entries and out-of-range addresses
    send(1, 0, 2, 5);
    send(1, 1, -2, 3);
    send(2, 0, 0, 0);
    send(2, 1, 0, 0);
    send(1, 6, 9, 9);
    send(2, 6, 0, 0);
    wait_drain();

    // Randomized traffic with random back-pressure
    rand_bp = 1'b1;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 7) == 0) begin
        @(posedge clk);
        #1;
      end else begin
        send(int'($urandom_range(0, 3)), int'($urandom_range(0, 7)),
             int'($urandom_range(0, 255)) - 128, int'($urandom_range(0, 255)) - 128);
      end
    end
    rand_bp = 1'b0;
    wait_drain();

    // Reset while a result is pending
    hold_lo = 1'b1;
    send(2, 0, 0, 0);
    t = 0;
    while (!(&ov) && t < 20) begin
      @(posedge clk);
      #1;
      t++;
    end
    for (int k = 0; k < N; k++) chk($sformatf("pending_before_rst[%0d]", k), ov[k], 1);
    rst = 1'b1;
    @(negedge clk);
    for (int k = 0; k < N; k++) chk($sformatf("in_ready_in_rst[%0d]", k), rdy[k], 0);
    @(posedge clk);
    #1;
    for (int k = 0; k < N; k++) chk($sformatf("out_valid_after_rst[%0d]", k), ov[k], 0);
    rst = 1'b0;
    model_clear();
    hold_lo = 1'b0;
    for (int a = 0; a < 8; a++) send(2, a, 0, 0);
    wait_drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
